// File: rtl/bindct_pkg.sv
// Shared constants, types and shift-add constant multipliers for the
// forward and inverse 8-point binDCT.
package bindct_pkg;

  localparam int FP_SIZE   = 32;  // signed Q19.12 coefficient width
  localparam int FRAC_BITS = 12;  // fractional bits dropped at the output
  localparam int OUT_SIZE  = 8;   // reconstructed sample width

  typedef logic signed [FP_SIZE-1:0]  coef_t;
  typedef logic signed [OUT_SIZE-1:0] pix_t;

  // Output clip bounds and rounding constant, held at coefficient width
  localparam coef_t PIX_MAX    = coef_t'((1 << (OUT_SIZE - 1)) - 1);
  localparam coef_t PIX_MIN    = -coef_t'(1 << (OUT_SIZE - 1));
  localparam coef_t ROUND_HALF = coef_t'(1 << (FRAC_BITS - 1));

  // v * 3/8
  function automatic coef_t f38(input coef_t v);
    return (v >>> 2) + (v >>> 3);
  endfunction

  // v * 7/8
  function automatic coef_t f78(input coef_t v);
    return (v >>> 1) + (v >>> 2) + (v >>> 3);
  endfunction

  // v * 5/8
  function automatic coef_t f58(input coef_t v);
    return (v >>> 1) + (v >>> 3);
  endfunction

endpackage

// File: rtl/ibindct_bfly2.sv
// Halving butterfly: sum and difference of two coefficients, each >>>1.
module ibindct_bfly2
  import bindct_pkg::*;
(
  input  coef_t a,
  input  coef_t b,
  output coef_t sum,
  output coef_t dif
);

  assign sum = (a + b) >>> 1;
  assign dif = (a - b) >>> 1;

endmodule

// File: rtl/ibindct_8pt.sv
// Pipelined 8-point inverse binDCT (4 stages, shift-add lifting only).
// Optional build macro IBINDCT_SAT_EN: round-to-nearest output with
// saturation and a sat flag; when undefined the output truncates and wraps.
module ibindct_8pt
  import bindct_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [7:0][FP_SIZE-1:0]      x_in,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [7:0][OUT_SIZE-1:0]     x_out,
  output logic                         out_last,
  output logic                         sat
);

  logic adv;
  logic s1_valid_reg, s2_valid_reg, s3_valid_reg, s4_valid_reg;
  logic [2:0] cnt_reg;

  // S1 holds butterfly pairs as (p[i], p[i+4]): (c0,c3) (c1,c2) (c4,c5) (c7,c6)
  coef_t s1_p_reg [8];
  // S2 holds sums in [0..3] and differences in [4..7]: a0 a1 a4 a7 / a3 a2 b1 b0
  coef_t s2_q_reg [8];
  // S3 holds a0..a7 in natural order
  coef_t s3_a_reg [8];
  pix_t  x_out_reg [8];
  logic  sat_reg;

  coef_t xi [8];
  coef_t c0, c1, c2, c3, c4, c5, c6, c7;
  coef_t s2_sum [4], s2_dif [4];
  coef_t b0, b1, a5, a6;
  coef_t s4_sum [4], s4_dif [4];
  coef_t s4_lane [8];
  pix_t  lane_pix [8];
  logic [7:0] lane_clip;

  // Whole pipeline moves together whenever the output slot is free or drained
  assign adv       = out_ready | ~s4_valid_reg;
  assign in_ready  = adv;
  assign out_valid = s4_valid_reg;
  assign out_last  = s4_valid_reg & (cnt_reg == 3'd7);
  assign sat       = sat_reg;

  genvar gi;
  for (gi = 0; gi < 8; gi++) begin : g_io
    assign xi[gi]    = coef_t'(x_in[gi]);
    assign x_out[gi] = x_out_reg[gi];
  end

  // S1: undo the forward lifting steps
  always_comb begin
    c1 = (xi[0] >>> 1) - xi[4];
    c0 = xi[0] - c1;
    c3 = xi[2] - f38(xi[6]);
    c2 = xi[6] + f38(c3);
    c6 = xi[3] + (xi[5] >>> 1);
    c5 = xi[5] - f78(c6);
    c7 = xi[1];
    c4 = xi[7] + (c7 >>> 3);
  end

  // S2: four halving butterflies on the S1 pairs
  for (gi = 0; gi < 4; gi++) begin : g_s2
    ibindct_bfly2 u_bfly (
      .a   (s1_p_reg[gi]),
      .b   (s1_p_reg[gi+4]),
      .sum (s2_sum[gi]),
      .dif (s2_dif[gi])
    );
  end

  // S3: odd-part rotation lifting recovers a5/a6 from b0/b1
  assign b0 = s2_q_reg[7];
  assign b1 = s2_q_reg[6];
  assign a5 = f58(b0) - b1;
  assign a6 = b0 - f38(a5);

  // S4: mirror butterflies, x[i] from the sum and x[7-i] from the difference
  for (gi = 0; gi < 4; gi++) begin : g_s4
    ibindct_bfly2 u_bfly (
      .a   (s3_a_reg[gi]),
      .b   (s3_a_reg[7-gi]),
      .sum (s4_sum[gi]),
      .dif (s4_dif[gi])
    );
    assign s4_lane[gi]   = s4_sum[gi];
    assign s4_lane[7-gi] = s4_dif[gi];
  end

  // Output formatting: drop the fraction and fit each lane into OUT_SIZE
  for (gi = 0; gi < 8; gi++) begin : g_fmt
`ifdef IBINDCT_SAT_EN
    coef_t rnd;
    assign rnd             = (s4_lane[gi] + ROUND_HALF) >>> FRAC_BITS;
    assign lane_clip[gi]   = (rnd > PIX_MAX) || (rnd < PIX_MIN);
    assign lane_pix[gi]    = (rnd > PIX_MAX) ? pix_t'(PIX_MAX) :
                             (rnd < PIX_MIN) ? pix_t'(PIX_MIN) : pix_t'(rnd);
`else
    assign lane_clip[gi]   = 1'b0;
    assign lane_pix[gi]    = pix_t'(s4_lane[gi] >>> FRAC_BITS);
`endif
  end

  // Stage valid bits and the visible output register (cleared by reset)
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_reg <= 1'b0;
      s2_valid_reg <= 1'b0;
      s3_valid_reg <= 1'b0;
      s4_valid_reg <= 1'b0;
      sat_reg      <= 1'b0;
      for (int i = 0; i < 8; i++) x_out_reg[i] <= '0;
    end else if (adv) begin
      s1_valid_reg <= in_valid;
      s2_valid_reg <= s1_valid_reg;
      s3_valid_reg <= s2_valid_reg;
      s4_valid_reg <= s3_valid_reg;
      sat_reg      <= |lane_clip;
      for (int i = 0; i < 8; i++) x_out_reg[i] <= lane_pix[i];
    end
  end

  // Internal stage data; qualified by the valid bits, so no reset needed
  always_ff @(posedge clk) begin
    if (adv) begin
      s1_p_reg[0] <= c0;  s1_p_reg[4] <= c3;
      s1_p_reg[1] <= c1;  s1_p_reg[5] <= c2;
      s1_p_reg[2] <= c4;  s1_p_reg[6] <= c5;
      s1_p_reg[3] <= c7;  s1_p_reg[7] <= c6;
      for (int i = 0; i < 4; i++) begin
        s2_q_reg[i]   <= s2_sum[i];
        s2_q_reg[i+4] <= s2_dif[i];
      end
      s3_a_reg[0] <= s2_q_reg[0];
      s3_a_reg[1] <= s2_q_reg[1];
      s3_a_reg[2] <= s2_q_reg[5];
      s3_a_reg[3] <= s2_q_reg[4];
      s3_a_reg[4] <= s2_q_reg[2];
      s3_a_reg[5] <= a5;
      s3_a_reg[6] <= a6;
      s3_a_reg[7] <= s2_q_reg[3];
    end
  end

  // Row counter within an 8x8 block, stepped on every consumed vector
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg <= 3'd0;
    end else if (s4_valid_reg && out_ready) begin
      cnt_reg <= cnt_reg + 3'd1;
    end
  end

endmodule
